// File: rtl/fetch_stage_if.sv
// fetch_stage_if: handshake/bus bundle between the fetch stage, its
// instruction memory, the hazard unit and the ID-stage decoder.
//   stall        hazard unit -> fetch : hold PC and IF/ID
//   redirect     ID -> fetch          : branch taken / jump this cycle
//   redirect_pc  ID -> fetch          : redirect target
//   imem_addr    fetch -> imem        : word address (= pc)
//   imem_data    imem -> fetch        : instruction word, same cycle
//   pc           fetch -> observers   : current fetch PC
//   if_id_instr  fetch -> decoder     : latched instruction
//   if_id_pc4    fetch -> decoder     : latched PC+4 of that instruction
//   if_id_valid  fetch -> decoder     : IF/ID holds a real instruction
//   reg_reset    fetch -> decoder     : squash, equals ~if_id_valid
// slave modport is the fetch stage; master modport is its environment.
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        reg_reset;

  modport slave (
    input  stall, redirect, redirect_pc, imem_data,
    output imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, reg_reset
  );

  modport master (
    output stall, redirect, redirect_pc, imem_data,
    input  imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid, reg_reset
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register of the
// 5-stage MIPS pipeline.
// Ports:
//   clk    pipeline clock, all state updates on the rising edge
//   reset  synchronous active-high reset (overrides stall and redirect)
//   bus    fetch_stage_if.slave (stall/redirect in, imem port, IF/ID out)
// Parameters:
//   RESET_PC  PC loaded on reset
//   NOP_WORD  word inserted into IF/ID on a bubble or flush
// Configuration macro:
//   BRANCH_DELAY_SLOT_EN  defined: the instruction fetched alongside a
//   redirect is kept as a valid delay-slot instruction. Undefined (default):
//   that instruction is squashed to NOP_WORD with valid=0.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.slave  bus
);

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;
  logic [31:0] pc_plus4;
  logic [31:0] target_pc;

  // Sequential successor wraps naturally modulo 2^32. Redirect targets are
  // word-aligned by clearing the two low bits; no range check is applied.
  assign pc_plus4  = pc_q + 32'd4;
  assign target_pc = bus.redirect_pc & ~32'd3;

  // PC and IF/ID register. Priority: reset > stall > redirect > sequential.
  // A redirect seen during a stall is dropped; the stalled ID instruction
  // re-asserts it once the stall clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      pc4_q <= pc_plus4;
      if (bus.redirect) begin
        pc_q <= target_pc;
`ifdef BRANCH_DELAY_SLOT_EN
        instr_q <= bus.imem_data;
        valid_q <= 1'b1;
`else
        instr_q <= NOP_WORD;
        valid_q <= 1'b0;
`endif
      end else begin
        pc_q    <= pc_plus4;
        instr_q <= bus.imem_data;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc4   = pc4_q;
  assign bus.if_id_valid = valid_q;
  assign bus.reg_reset   = ~valid_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline; sits directly upstream of the control decoder.
- Holds the PC, drives the instruction-memory address, selects the next PC, and latches the fetched word into IF/ID.
- Branch/jump redirects arrive from ID (decoder outputs already resolved into taken/target). In response, the stage kills the wrong-path fetch and drives the decoder's squash input (regReset).

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on a bubble or flush.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  load-use hold from hazard unit; freezes PC and IF/ID.
- redirect  in  1  ID-stage branch taken or jump (j/jal/jr/jalr) this cycle.
- redirect_pc  in  32  target PC for redirect.
- imem_addr  out  32  instruction-memory word address (= pc); memory read is combinational.
- imem_data  in  32  instruction word at imem_addr, same cycle.
- pc  out  32  current fetch PC.
- if_id_instr  out  32  latched instruction; op = [31:26] and func = [5:0] feed the decoder.
- if_id_pc4  out  32  latched PC+4 of that instruction, used for link and branch-offset math.
- if_id_valid  out  1  IF/ID holds a real instruction.
- reg_reset  out  1  squash to decoder; equals ~if_id_valid.

Behaviour:
- Reset: on the clock edge with reset=1:
  - pc <= RESET_PC.
  - if_id_instr <= NOP_WORD; if_id_pc4 <= 0; if_id_valid <= 0.
  - Therefore reg_reset = 1 after reset.
  - Reset overrides stall and redirect in the same cycle, including a reset that arrives mid-stall or mid-redirect.
- PC update priority per edge: reset > stall > redirect > sequential.
  - stall=1: pc and all IF/ID fields hold. Any redirect in the same cycle is ignored; the held ID instruction re-asserts it once stall drops.
  - redirect=1, stall=0: pc <= {redirect_pc[31:2], 2'b00}. Low target bits are always forced to zero.
  - Otherwise: pc <= pc + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- IF/ID update, when not reset and not stall:
  - redirect=0: if_id_instr <= imem_data; if_id_pc4 <= pc + 4; if_id_valid <= 1.
  - redirect=1: behaviour depends on the optional feature below.
- imem_addr = pc at all times, combinational.
- Latency: an instruction at address A appears on if_id_instr one edge after pc = A, provided there is no stall.
- A redirect taken at edge N fetches the target during cycle N+1. The target is in IF/ID after edge N+1.
- Back-to-back redirects: each is honoured independently. A flushed slot (valid=0) must never generate a redirect; the decoder is squashed by reg_reset.
- The block does not check redirect_pc for validity; an out-of-range target is fetched as-is.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined (MIPS delay-slot semantics): on redirect the IF/ID register loads imem_data normally with valid=1, so the delay-slot instruction executes.
- Undefined (default): on redirect the IF/ID register loads NOP_WORD with valid=0, so the wrong-path instruction is squashed and reg_reset=1 for exactly one cycle per redirect.

Test Plan:
- Reset then run with imem returning addr-derived words -> pc sequence 3000, 3004, 3008; if_id_pc4 = 3004 while holding word@3000; valid=1 from the second edge.
- stall=1 for 3 cycles at pc=3008 -> pc, if_id_instr and if_id_pc4 unchanged for 3 edges; resume at 300C next.
- redirect=1 with redirect_pc=32'h0000_3043 at pc=3010 -> pc=3040. Without the macro: IF/ID=NOP, valid=0, reg_reset=1 for one cycle. With the macro: IF/ID holds word@3010, valid=1.
- stall=1 and redirect=1 together -> no pc change. Stall drops with redirect still high -> redirect taken on the next edge.
- pc forced to FFFF_FFFC via redirect, then sequential -> pc wraps to 0000_0000; if_id_pc4 = 0.
- reset asserted during stall+redirect -> pc=3000, valid=0, reg_reset=1 on that edge.
